// File: rtl/matrix_result_streamer.sv
// Purpose: snapshots a packed 5x5 product matrix on start and streams its c_m x c_n elements row-major.
// Latency: first element presented the cycle after an accepted start; one element per beat thereafter.
// Backpressure: valid/ready; all outputs hold while o_out_valid && !i_out_ready.
module matrix_result_streamer #(
    parameter int ELEM_W  = 16,
    parameter int MAX_DIM = 5
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_start,
    input  logic                                i_in_valid,
    input  logic                                i_in_error,
    input  logic [2:0]                          i_c_m,
    input  logic [2:0]                          i_c_n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   i_mat_in,
    output logic [ELEM_W-1:0]                   o_out_data,
    output logic [2:0]                          o_out_row,
    output logic [2:0]                          o_out_col,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    output logic                                o_out_last_col,
    output logic                                o_out_last,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_err
);

    localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t             r_state;
    logic [MAT_W-1:0]   r_buf;
    logic [2:0]         r_cm;
    logic [2:0]         r_cn;
    logic [ELEM_W-1:0]  r_data;
    logic [2:0]         r_row;
    logic [2:0]         r_col;
    logic               r_valid;
    logic               r_last_col;
    logic               r_last;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_cap_ok;
    logic               w_beat;
    logic               w_row_end;
    logic [2:0]         w_nrow;
    logic [2:0]         w_ncol;
    logic [8:0]         w_off;
    logic [ELEM_W-1:0]  w_next_data;
    logic               w_next_last_col;
    logic               w_next_last;

    assign w_cap_ok = i_in_valid && !i_in_error
                   && (i_c_m >= 3'd1) && (i_c_m <= 3'(MAX_DIM))
                   && (i_c_n >= 3'd1) && (i_c_n <= 3'(MAX_DIM));

    assign w_beat = r_valid && i_out_ready;

    // Next position after a non-final beat; the row never advances past the
    // last captured row, so the element offset always stays inside r_buf.
    assign w_row_end = (r_col == r_cn - 3'd1);
    assign w_ncol    = w_row_end ? 3'd0 : r_col + 3'd1;
    assign w_nrow    = (w_row_end && (r_row != r_cm - 3'd1)) ? r_row + 3'd1 : r_row;

    assign w_off           = ((9'(w_nrow) * 9'(MAX_DIM)) + 9'(w_ncol)) * 9'(ELEM_W);
    assign w_next_data     = r_buf[w_off +: ELEM_W];
    assign w_next_last_col = (w_ncol == r_cn - 3'd1);
    assign w_next_last     = w_next_last_col && (w_nrow == r_cm - 3'd1);

    // Control FSM with every output registered, so nothing downstream sees a path from i_out_ready.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_cm       <= 3'd0;
            r_cn       <= 3'd0;
            r_data     <= '0;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_valid    <= 1'b0;
            r_last_col <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_cap_ok) begin
                            r_buf      <= i_mat_in;
                            r_cm       <= i_c_m;
                            r_cn       <= i_c_n;
                            r_row      <= 3'd0;
                            r_col      <= 3'd0;
                            r_data     <= i_mat_in[ELEM_W-1:0];
                            r_valid    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_last_col <= (i_c_n == 3'd1);
                            r_last     <= (i_c_n == 3'd1) && (i_c_m == 3'd1);
                            r_state    <= S_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_beat) begin
                        if (r_last) begin
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_last_col <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_row      <= w_nrow;
                            r_col      <= w_ncol;
                            r_data     <= w_next_data;
                            r_last_col <= w_next_last_col;
                            r_last     <= w_next_last;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_out_data     = r_data;
    assign o_out_row      = r_row;
    assign o_out_col      = r_col;
    assign o_out_valid    = r_valid;
    assign o_out_last_col = r_last_col;
    assign o_out_last     = r_last;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err          = r_err;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Purpose: randomized self-checking bench for matrix_result_streamer against a row-major queue model.
// Latency: expects first element one cycle after start and done one cycle after the final beat.
// Backpressure: drives out_ready always-high, toggling or random and expects held outputs on stalls.
module tb_matrix_result_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_error;
    logic [2:0]   c_m;
    logic [2:0]   c_n;
    logic [399:0] mat_in;
    logic [15:0]  out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_valid;
    logic         out_ready;
    logic         out_last_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  r;
        logic [2:0]  c;
        logic        lc;
        logic        l;
    } beat_t;

    matrix_result_streamer dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_in_valid     (in_valid),
        .i_in_error     (in_error),
        .i_c_m          (c_m),
        .i_c_n          (c_n),
        .i_mat_in       (mat_in),
        .o_out_data     (out_data),
        .o_out_row      (out_row),
        .o_out_col      (out_col),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_last_col (out_last_col),
        .o_out_last     (out_last),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(out_data), 0);
        check({tag, "_row"},   32'(out_row), 0);
        check({tag, "_col"},   32'(out_col), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_lc"},    32'(out_last_col), 0);
        check({tag, "_last"},  32'(out_last), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_err"},   32'(err), 0);
    endtask

    function automatic logic [399:0] rand_mat();
        logic [415:0] t;
        for (int k = 0; k < 13; k++) t[k*32 +: 32] = $urandom;
        return t[399:0];
    endfunction

    // mode: 0 ready always high, 1 toggles 1,0,1,0, 2 random
    // pat:  0 random, 1 sequential 1.., 2 100*i+j
    task automatic run_stream(input int cm, input int cn, input int mode, input bit mutate,
                              input bit bstart, input int abort_after, input int pat);
        logic [15:0]  m [5][5];
        logic [399:0] mat;
        beat_t        q [$];
        beat_t        b;
        int           cyc;
        int           beats;
        bit           fin;
        bit           rdy;

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                case (pat)
                    1:       m[i][j] = 16'(i * cn + j + 1);
                    2:       m[i][j] = 16'(100 * i + j);
                    default: m[i][j] = 16'($urandom);
                endcase
                mat[(i*5+j)*16 +: 16] = m[i][j];
            end
        for (int i = 0; i < cm; i++)
            for (int j = 0; j < cn; j++) begin
                b.d  = m[i][j];
                b.r  = 3'(i);
                b.c  = 3'(j);
                b.lc = (j == cn - 1);
                b.l  = (i == cm - 1) && (j == cn - 1);
                q.push_back(b);
            end

        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(out_valid), 0);
        check("idle_done", 32'(done), 0);
        start     = 1'b1;
        in_valid  = 1'b1;
        in_error  = 1'b0;
        c_m       = 3'(cm);
        c_n       = 3'(cn);
        mat_in    = mat;
        out_ready = 1'b0;

        cyc   = 0;
        beats = 0;
        fin   = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = bstart && (cyc == 3);
            if (mutate) begin
                mat_in = rand_mat();
                c_n    = 3'($urandom_range(1, 5));
                c_m    = 3'($urandom_range(1, 5));
            end
            check("err_quiet", 32'(err), 0);
            if (q.size() > 0) begin
                check("valid", 32'(out_valid), 1);
                check("busy", 32'(busy), 1);
                check("done_early", 32'(done), 0);
                check("data", 32'(out_data), 32'(q[0].d));
                check("row", 32'(out_row), 32'(q[0].r));
                check("col", 32'(out_col), 32'(q[0].c));
                check("last_col", 32'(out_last_col), 32'(q[0].lc));
                check("last", 32'(out_last), 32'(q[0].l));
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = cyc[0];
                    default: rdy = 1'($urandom);
                endcase
                out_ready = rdy;
                if (rdy) begin
                    void'(q.pop_front());
                    beats++;
                    if (abort_after != 0 && beats == abort_after) begin
                        @(negedge clk);
                        rst = 1'b1;
                        #1;
                        check_all_zero("reset_mid");
                        @(negedge clk);
                        check_all_zero("reset_hold");
                        rst = 1'b0;
                        q.delete();
                        fin = 1'b1;
                    end
                end
            end else begin
                check("done", 32'(done), 1);
                check("done_valid", 32'(out_valid), 0);
                check("done_busy", 32'(busy), 1);
                out_ready = 1'b0;
                fin = 1'b1;
            end
        end
        check("stream_left", 32'(q.size()), 0);
        start = 1'b0;
    endtask

    task automatic reject(input string tag, input bit v, input bit e, input int cm, input int cn);
        @(negedge clk);
        start    = 1'b1;
        in_valid = v;
        in_error = e;
        c_m      = 3'(cm);
        c_n      = 3'(cn);
        mat_in   = rand_mat();
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, 32'(err), 1);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        @(negedge clk);
        check({tag, "_err_clear"}, 32'(err), 0);
        check({tag, "_valid2"}, 32'(out_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_error  = 1'b0;
        c_m       = 3'd0;
        c_n       = 3'd0;
        mat_in    = '0;
        out_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_stream(2, 3, 0, 1'b0, 1'b0, 0, 1);
        run_stream(5, 5, 1, 1'b0, 1'b0, 0, 2);

        reject("rej_error", 1'b1, 1'b1, 3, 3);
        reject("rej_cm0",   1'b1, 1'b0, 0, 3);
        reject("rej_cn6",   1'b1, 1'b0, 3, 6);
        reject("rej_novld", 1'b0, 1'b0, 3, 3);

        run_stream(3, 3, 0, 1'b1, 1'b1, 0, 0);

        run_stream(4, 4, 0, 1'b0, 1'b0, 4, 0);
        run_stream(1, 1, 0, 1'b0, 1'b0, 0, 0);

        run_stream(1, 5, 0, 1'b0, 1'b0, 0, 0);
        run_stream(2, 2, 0, 1'b0, 1'b0, 0, 0);

        for (int k = 0; k < 8; k++)
            run_stream($urandom_range(1, 5), $urandom_range(1, 5), 2, k[0], 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
